// File: rtl/uart_rx_if.sv
// Bundles the UART receiver's configuration, serial line and received-frame outputs.
// Latency: none; this file only groups wires.
// Backpressure: none; the received word is a strobe with no ready.
interface uart_rx_if;
  logic [1:0]  parity;        // 0/1 none, 2 even, 3 odd
  logic [3:0]  width;         // data bits per frame, 0 means 16
  logic        in;            // serial line, idle high
  logic [15:0] bits;          // received word, LSB first on the line
  logic        valid;         // one-cycle strobe for bits and error flags
  logic        parity_error;
  logic        frame_error;
  logic        busy;

  // Line and configuration source (pad side / testbench)
  modport master (
    output parity, width, in,
    input  bits, valid, parity_error, frame_error, busy
  );

  // Receiver side
  modport slave (
    input  parity, width, in,
    output bits, valid, parity_error, frame_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 1-16 data bits LSB first, optional parity, one stop bit.
// Latency: valid rises (1+N+P)*OVERSAMPLE + OVERSAMPLE/2 + SYNC_STAGES + 1 cycles after the start edge.
// Backpressure: none; valid is a one-cycle strobe and results hold until the next valid.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,  // clock cycles per bit, even and >= 4
  parameter int SYNC_STAGES = 2    // synchronizer depth on the line, >= 2
) (
  input logic      clock,
  input logic      reset,          // asynchronous, active-low
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t      state;
  logic [CW-1:0] c;
  logic [4:0]  idx;
  logic [4:0]  cfg_w;        // captured width, 1..16
  logic [1:0]  cfg_par;      // captured parity mode
  logic [15:0] shift_q;
  logic        p;            // running XOR of data bits
  logic        perr;
  logic [15:0] bits_q;
  logic        valid_q;
  logic        parity_error_q;
  logic        frame_error_q;
  logic        busy_q;

  // Line synchronizer, preset to idle-high so reset never looks like a start bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx.in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Frame state machine; every output is registered here
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      c              <= '0;
      idx            <= '0;
      cfg_w          <= 5'd16;
      cfg_par        <= 2'd0;
      shift_q        <= '0;
      p              <= 1'b0;
      perr           <= 1'b0;
      bits_q         <= '0;
      valid_q        <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!s) begin
            state   <= START;
            c       <= '0;
            busy_q  <= 1'b1;
            cfg_par <= rx.parity;
            cfg_w   <= (rx.width == 4'd0) ? 5'd16 : {1'b0, rx.width};
          end
        end

        START: begin
          if (c == C_HALF) begin
            c <= '0;
            if (s) begin
              // Line came back high before mid-bit: a glitch, not a frame
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              shift_q <= '0;
              p       <= 1'b0;
              perr    <= 1'b0;
              idx     <= '0;
              state   <= DATA;
            end
          end else begin
            c <= c + 1'b1;
          end
        end

        DATA: begin
          if (c == C_FULL) begin
            c                <= '0;
            shift_q[idx[3:0]] <= s;
            p                <= p ^ s;
            idx              <= idx + 5'd1;
            if (idx + 5'd1 == cfg_w) begin
              state <= cfg_par[1] ? PARITY : STOP;
            end
          end else begin
            c <= c + 1'b1;
          end
        end

        PARITY: begin
          if (c == C_FULL) begin
            c     <= '0;
            perr  <= s ^ p ^ cfg_par[0];
            state <= STOP;
          end else begin
            c <= c + 1'b1;
          end
        end

        STOP: begin
          if (c == C_FULL) begin
            c <= '0;
            // shift_q was cleared at start, so bits above the width are already zero
            bits_q         <= shift_q;
            parity_error_q <= cfg_par[1] & perr;
            frame_error_q  <= ~s;
            valid_q        <= 1'b1;
            if (s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end else begin
            c <= c + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // Break condition: do not re-arm until the line has returned high
          if (s) begin
            state  <= IDLE;
            c      <= '0;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          c      <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.bits         = bits_q;
  assign rx.valid        = valid_q;
  assign rx.parity_error = parity_error_q;
  assign rx.frame_error  = frame_error_q;
  assign rx.busy         = busy_q;

endmodule
